// File: rtl/gfx_fetch.sv
// gfx_fetch: prefetches the six bitplane bytes of the next 8-pixel column over a req/ack VRAM port.
// Optional: define GFX_FETCH_MASK_SKIP_EN to skip planes whose mask bit is clear.
module gfx_fetch #(
    parameter logic [12:0] BASE       = 13'h0ec0,
    parameter int          LINE_BYTES = 24,
    parameter int          V_ACTIVE   = 184,
    parameter int          H_COLS     = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [8:0]  h,
    input  logic [8:0]  v,
    input  logic [5:0]  mask,
    output logic        mem_req,
    output logic [2:0]  mem_plane,
    output logic [12:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [7:0]  fg1,
    output logic [7:0]  fg2,
    output logic [7:0]  fg3,
    output logic [7:0]  bg1,
    output logic [7:0]  bg2,
    output logic [7:0]  bg3,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      plane, plane_nxt;
    logic [12:0]     addr, addr_nxt;
    logic [5:0][7:0] shadow, shadow_ack, shadow_nxt, pix;
    logic            load, fetch, last_ack;
    logic [6:0]      col_inc, col;
    logic [9:0]      vf;
    logic [12:0]     addr_calc;
    logic [5:0]      en_load, en_run;
    logic [3:0]      first_plane, next_plane;

    // Lowest enabled plane at or above 'from'; 6 means none left.
    function automatic logic [3:0] first_en(input logic [5:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd6;
        for (int i = 5; i >= 0; i--)
            if (i >= int'(from) && m[i]) r = 4'(i);
        return r;
    endfunction

    assign load      = ce_pix && (h[2:0] == 3'd0);
    assign col_inc   = {1'b0, h[8:3]} + 7'd1;
    assign col       = (int'(col_inc) >= H_COLS) ? 7'd0 : col_inc;
    assign vf        = (col == 7'd0) ? {1'b0, v} + 10'd1 : {1'b0, v};
    assign fetch     = (int'(col) < LINE_BYTES) && (int'(vf) < V_ACTIVE);
    assign addr_calc = 13'(32'(BASE) + 32'(vf) * 32'(LINE_BYTES) + 32'(col));

`ifdef GFX_FETCH_MASK_SKIP_EN
    logic [5:0] mask_q;

    always_ff @(posedge clk) begin
        if (reset)
            mask_q <= '0;
        else if (load)
            mask_q <= mask;
    end

    assign en_load = mask;
    assign en_run  = mask_q;
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign en_load     = 6'h3f;
    assign en_run      = 6'h3f;
`endif

    assign first_plane = first_en(en_load, 4'd0);
    assign next_plane  = first_en(en_run, {1'b0, plane} + 4'd1);
    // An ack finishing the last plane on the load edge still counts as a completed fetch.
    assign last_ack    = (state == REQ) && mem_ack && (next_plane == 4'd6);

    always_comb begin
        shadow_ack = shadow;
        if (state == REQ && mem_ack) begin
            for (int i = 0; i < 6; i++)
                if (plane == 3'(i)) shadow_ack[i] = mem_data;
        end
        state_nxt  = state;
        plane_nxt  = plane;
        addr_nxt   = addr;
        shadow_nxt = shadow_ack;
        if (load) begin
            if (fetch) begin
                addr_nxt = addr_calc;
                for (int i = 0; i < 6; i++)
                    if (!en_load[i]) shadow_nxt[i] = 8'd0;
                if (first_plane == 4'd6) begin
                    state_nxt = DONE;
                    plane_nxt = 3'd0;
                end else begin
                    state_nxt = REQ;
                    plane_nxt = first_plane[2:0];
                end
            end else begin
                state_nxt  = IDLE;
                plane_nxt  = 3'd0;
                shadow_nxt = '0;
            end
        end else if (state == REQ && mem_ack) begin
            if (next_plane == 4'd6)
                state_nxt = DONE;
            else
                plane_nxt = next_plane[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            plane   <= 3'd0;
            addr    <= 13'd0;
            shadow  <= '0;
            pix     <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_nxt;
            plane  <= plane_nxt;
            addr   <= addr_nxt;
            shadow <= shadow_nxt;
            if (load)
                pix <= shadow_ack;
            if (load && state == REQ && !last_ack)
                overrun <= 1'b1;
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_plane = plane;
    assign mem_addr  = addr;
    assign fg1       = pix[0];
    assign fg2       = pix[1];
    assign fg3       = pix[2];
    assign bg1       = pix[3];
    assign bg2       = pix[4];
    assign bg3       = pix[5];
endmodule

// File: tb/tb_gfx_fetch.sv
// Directed bench for gfx_fetch with a queue-based column model and a responding VRAM arbiter.
module tb_gfx_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce_pix, mem_ack, mem_req, overrun;
    logic [8:0]  h, v;
    logic [5:0]  mask;
    logic [2:0]  mem_plane;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;

    gfx_fetch dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .h(h), .v(v), .mask(mask),
        .mem_req(mem_req), .mem_plane(mem_plane), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .fg1(fg1), .fg2(fg2), .fg3(fg3), .bg1(bg1), .bg2(bg2), .bg3(bg3),
        .overrun(overrun)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // model: shadow bytes, presented bytes, outstanding planes of the current fetch
    int exp_shadow[6];
    int exp_pix[6];
    int exp_pending[$];
    int exp_addr;
    bit exp_overrun;

    // arbiter state
    int ack_wait[6];
    int data_ofs, wcnt, prev_plane, force_data;
    bit prev_req, prev_ack, force_ack;
    int hp, vp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit plane_on(input int p);
`ifdef GFX_FETCH_MASK_SKIP_EN
        return mask[p];
`else
        return (p >= 0);
`endif
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 6; p++) begin
            exp_shadow[p] = 0;
            exp_pix[p] = 0;
        end
        exp_pending.delete();
        exp_addr = 0;
        exp_overrun = 0;
    endtask

    task automatic model_step();
        int c, vf;
        if (reset) begin
            model_clear();
            return;
        end
        if (mem_ack && exp_pending.size() != 0) begin
            exp_shadow[exp_pending[0]] = int'(mem_data);
            void'(exp_pending.pop_front());
        end
        if (ce_pix && (int'(h) % 8 == 0)) begin
            exp_pix = exp_shadow;
            if (exp_pending.size() != 0) exp_overrun = 1;
            exp_pending.delete();
            c = (int'(h) / 8 + 1) % 40;
            vf = (c == 0) ? int'(v) + 1 : int'(v);
            if (c < 24 && vf < 184) begin
                exp_addr = (3776 + vf * 24 + c) % 8192;
                for (int p = 0; p < 6; p++)
                    if (plane_on(p)) exp_pending.push_back(p);
                    else exp_shadow[p] = 0;
            end else begin
                for (int p = 0; p < 6; p++) exp_shadow[p] = 0;
            end
        end
    endtask

    task automatic arb();
        mem_ack = 1'b0;
        mem_data = 8'h00;
        if (force_ack) begin
            mem_ack = 1'b1;
            mem_data = 8'(force_data);
        end else if (mem_req === 1'b1) begin
            if (!prev_req || prev_ack || int'(mem_plane) != prev_plane) wcnt = 0;
            if (wcnt >= ack_wait[mem_plane]) begin
                mem_ack = 1'b1;
                mem_data = 8'(data_ofs + int'(mem_plane));
            end else begin
                wcnt++;
            end
        end
        prev_req = (mem_req === 1'b1);
        prev_ack = mem_ack;
        prev_plane = int'(mem_plane);
    endtask

    task automatic tick(input bit ce);
        ce_pix = ce;
        h = 9'(hp);
        v = 9'(vp);
        arb();
        model_step();
        @(negedge clk);
        if (ce) begin
            hp++;
            if (hp == 320) begin
                hp = 0;
                vp++;
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(exp_pending.size() != 0));
            if (exp_pending.size() != 0) begin
                chk("mem_plane", 32'(mem_plane), 32'(exp_pending[0]));
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            end
            chk("fg1", 32'(fg1), 32'(exp_pix[0]));
            chk("fg2", 32'(fg2), 32'(exp_pix[1]));
            chk("fg3", 32'(fg3), 32'(exp_pix[2]));
            chk("bg1", 32'(bg1), 32'(exp_pix[3]));
            chk("bg2", 32'(bg2), 32'(exp_pix[4]));
            chk("bg3", 32'(bg3), 32'(exp_pix[5]));
            chk("overrun", 32'(overrun), 32'(exp_overrun));
        end
    end

    initial begin
        reset = 1'b1; ce_pix = 1'b0; h = '0; v = '0; mask = 6'h3f;
        mem_ack = 1'b0; mem_data = '0;
        for (int i = 0; i < 6; i++) ack_wait[i] = 0;
        data_ofs = 0; wcnt = 0; prev_plane = 0; force_data = 0;
        prev_req = 0; prev_ack = 0; force_ack = 0;
        hp = 0; vp = 0;
        model_clear();
        chk_en = 1;

        tick(0);
        tick(0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_bg3", 32'(bg3), 32'd0);

        // reset while plane 3 is pending, then a stray ack
        reset = 0; ack_wait[3] = 5; data_ofs = 8'h90;
        repeat (6) tick(1);
        chk("pre_rst_plane3", 32'(mem_plane), 32'd3);
        reset = 1;
        tick(1);
        chk("midrst_req", 32'(mem_req), 32'd0);
        reset = 0; ack_wait[3] = 0;
        force_ack = 1; force_data = 8'h55;
        tick(0);
        force_ack = 0;
        tick(0);
        chk("late_ack_fg4", 32'(bg1), 32'd0);
        chk("late_ack_overrun", 32'(overrun), 32'd0);

        // first column, zero-wait arbiter
        hp = 0; vp = 0; data_ofs = 8'hA0;
        tick(1);
        chk("colB_req", 32'(mem_req), 32'd1);
        chk("colB_addr", 32'(mem_addr), 32'h0EC1);
        chk("colB_plane", 32'(mem_plane), 32'd0);
        repeat (7) tick(1);
        tick(1);
        chk("colB_fg1", 32'(fg1), 32'hA0);
        chk("colB_fg2", 32'(fg2), 32'hA1);
        chk("colB_fg3", 32'(fg3), 32'hA2);
        chk("colB_bg1", 32'(bg1), 32'hA3);
        chk("colB_bg2", 32'(bg2), 32'hA4);
        chk("colB_bg3", 32'(bg3), 32'hA5);
        repeat (7) tick(1);

        // last column of a line targets column 0 of the next line
        hp = 312; vp = 10; data_ofs = 8'hB0;
        tick(1);
        chk("wrap_addr", 32'(mem_addr), 32'h0FC8);
        repeat (7) tick(1);

        // bottom of the active area
        hp = 176; vp = 183; data_ofs = 8'hC0;
        tick(1);
        chk("last_line_addr", 32'(mem_addr), 32'h1FFF);
        repeat (7) tick(1);
        hp = 312; vp = 183;
        tick(1);
        chk("vblank_req", 32'(mem_req), 32'd0);
        chk("vblank_prev_fg1", 32'(fg1), 32'hC0);
        repeat (7) tick(1);
        tick(1);
        chk("vblank_fg1", 32'(fg1), 32'd0);
        chk("vblank_bg3", 32'(bg3), 32'd0);

        // right edge of the active area
        hp = 176; vp = 5; data_ofs = 8'hD0;
        tick(1);
        chk("col23_addr", 32'(mem_addr), 32'h0F4F);
        repeat (7) tick(1);
        tick(1);
        chk("hblank_req", 32'(mem_req), 32'd0);
        chk("hblank_prev_bg3", 32'(bg3), 32'hD5);
        repeat (7) tick(1);
        tick(1);
        chk("hblank_fg1", 32'(fg1), 32'd0);
        chk("hblank_fg3", 32'(fg3), 32'd0);

        // overrun: plane 4 stalls past the next load point, half-rate pixels
        hp = 0; vp = 20; data_ofs = 8'h60;
        repeat (8) tick(1);
        data_ofs = 8'h10; ack_wait[4] = 12;
        tick(1);
        chk("pre_ovr_bg2", 32'(bg2), 32'h64);
        while (hp < 16) begin
            tick(0);
            tick(1);
        end
        tick(0);
        data_ofs = 8'h20;
        tick(1);
        ack_wait[4] = 0;
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_fg1", 32'(fg1), 32'h10);
        chk("ovr_bg1", 32'(bg1), 32'h13);
        chk("ovr_bg2_old", 32'(bg2), 32'h64);
        chk("ovr_bg3_old", 32'(bg3), 32'h65);
        chk("ovr_restart_addr", 32'(mem_addr), 32'h10A3);
        chk("ovr_restart_plane", 32'(mem_plane), 32'd0);
        while (hp < 24) begin
            tick(0);
            tick(1);
        end

        // plane 4 ack lands on the load edge itself
        data_ofs = 8'h40; ack_wait[4] = 3;
        tick(1);
        chk("col3_fg1", 32'(fg1), 32'h20);
        repeat (7) tick(1);
        tick(1);
        ack_wait[4] = 0;
        chk("coin_bg1", 32'(bg1), 32'h43);
        chk("coin_bg2_new", 32'(bg2), 32'h44);
        chk("coin_bg3_old", 32'(bg3), 32'h25);
        chk("coin_overrun", 32'(overrun), 32'd1);

`ifdef GFX_FETCH_MASK_SKIP_EN
        repeat (7) tick(1);
        mask = 6'b000101; data_ofs = 8'h70;
        tick(1);
        repeat (7) tick(1);
        mask = 6'b000000;
        tick(1);
        chk("mask_fg1", 32'(fg1), 32'h70);
        chk("mask_fg2", 32'(fg2), 32'd0);
        chk("mask_fg3", 32'(fg3), 32'h72);
        chk("mask_bg1", 32'(bg1), 32'd0);
        chk("mask_bg2", 32'(bg2), 32'd0);
        chk("mask_bg3", 32'(bg3), 32'd0);
        chk("mask_none_req", 32'(mem_req), 32'd0);
        repeat (7) tick(1);
        tick(1);
        chk("mask_all_fg1", 32'(fg1), 32'd0);
        chk("mask_all_fg3", 32'(fg3), 32'd0);
        mask = 6'h3f;
`endif

        repeat (4) tick(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
